ball_frame_latch: RTL and testbench

- Downstream consumer of the processor/regfile ball coordinate outputs; sits between them and the VGA pixel path.
- Samples the 32-bit ball_x/ball_y once per frame, on the rising edge of screenEnd, and clamps them to the visible area.
- Holds the result stable for the whole next frame, so the display never tears mid-scan.
- Generates a pipelined per-pixel "ball hit" for the colour mux, plus a frame counter and an out-of-bounds flag.

---
 rtl/pong_pkg.sv | 17 +
 rtl/coord_clamp.sv | 25 ++
 rtl/ball_frame_latch.sv | 123 ++++++++++++
 tb/tb_ball_frame_latch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared screen geometry and control-state encoding for the pong display path.
package pong_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned BALL_SIZE = 8;

  // Largest top-left coordinate that keeps the whole ball on screen.
  localparam int unsigned X_MAX = SCREEN_W - BALL_SIZE;
  localparam int unsigned Y_MAX = SCREEN_H - BALL_SIZE;

  typedef enum logic {
    WAIT_FIRST,
    RUN
  } state_e;

endpackage

// File: rtl/coord_clamp.sv
// Clamps a signed 32-bit coordinate into [0, Limit] and reports whether it had to.
module coord_clamp #(
  parameter int unsigned Limit = 632,
  parameter int unsigned Width = 10
) (
  input  logic signed [31:0]      val,
  output logic        [Width-1:0] res,
  output logic                    clamped
);

  localparam logic signed [31:0] LimitS = Limit;

  always_comb begin
    res     = val[Width-1:0];
    clamped = 1'b0;
    if (val < 32'sd0) begin
      res     = '0;
      clamped = 1'b1;
    end else if (val > LimitS) begin
      res     = LimitS[Width-1:0];
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/ball_frame_latch.sv
// Latches the ball position once per frame on the rising edge of screenEnd and
// produces a 2-cycle pipelined per-pixel ball hit for the colour mux.
module ball_frame_latch
  import pong_pkg::*;
#(
  parameter int unsigned FCNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               screenEnd,
  input  logic signed [31:0] ball_x,
  input  logic signed [31:0] ball_y,
  input  logic        [9:0]  hcount,
  input  logic        [8:0]  vcount,
  input  logic               pix_valid,
  output logic        [9:0]  ball_px,
  output logic        [8:0]  ball_py,
  output logic               pos_valid,
  output logic               frame_tick,
  output logic [FCNT_W-1:0]  frame_count,
  output logic               oob,
  output logic               ball_pix,
  output logic               pix_valid_out
);

  state_e              state_q, state_d;
  logic                se_q;
  logic                rise;
  logic [9:0]          px_q, px_d, cx;
  logic [8:0]          py_q, py_d, cy;
  logic                oob_q, oob_d, cfx, cfy;
  logic                tick_q, tick_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                hx_q, hy_q, v1_q;
  logic                hx_d, hy_d;
  logic                pix_q, pvo_q;
  logic [10:0]         px_end;
  logic [9:0]          py_end;

  coord_clamp #(.Limit(X_MAX), .Width(10)) u_clamp_x (
    .val     (ball_x),
    .res     (cx),
    .clamped (cfx)
  );

  coord_clamp #(.Limit(Y_MAX), .Width(9)) u_clamp_y (
    .val     (ball_y),
    .res     (cy),
    .clamped (cfy)
  );

  assign rise = screenEnd & ~se_q;

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    oob_d   = oob_q;
    fcnt_d  = fcnt_q;
    tick_d  = 1'b0;
    if (rise) begin
      px_d    = cx;
      py_d    = cy;
      oob_d   = cfx | cfy;
      tick_d  = 1'b1;
      state_d = RUN;
      unique case (state_q)
        WAIT_FIRST: fcnt_d = FCNT_W'(1);
        RUN:        fcnt_d = fcnt_q + FCNT_W'(1);
        default:    fcnt_d = fcnt_q;
      endcase
    end
  end

  // One extra bit on the upper bound so px + BALL_SIZE never wraps near the right edge.
  always_comb begin
    px_end = {1'b0, px_q} + 11'(BALL_SIZE);
    py_end = {1'b0, py_q} + 10'(BALL_SIZE);
    hx_d   = ({1'b0, hcount} >= {1'b0, px_q}) && ({1'b0, hcount} < px_end);
    hy_d   = ({1'b0, vcount} >= {1'b0, py_q}) && ({1'b0, vcount} < py_end);
  end

  // History starts high so a blank already in progress at reset release is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_FIRST;
      se_q    <= 1'b1;
      px_q    <= '0;
      py_q    <= '0;
      oob_q   <= 1'b0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
      hx_q    <= 1'b0;
      hy_q    <= 1'b0;
      v1_q    <= 1'b0;
      pix_q   <= 1'b0;
      pvo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      se_q    <= screenEnd;
      px_q    <= px_d;
      py_q    <= py_d;
      oob_q   <= oob_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      v1_q    <= pix_valid;
      pix_q   <= hx_q & hy_q & v1_q & (state_q == RUN);
      pvo_q   <= v1_q;
    end
  end

  assign ball_px       = px_q;
  assign ball_py       = py_q;
  assign pos_valid     = (state_q == RUN);
  assign frame_tick    = tick_q;
  assign frame_count   = fcnt_q;
  assign oob           = oob_q;
  assign ball_pix      = pix_q;
  assign pix_valid_out = pvo_q;

endmodule

// File: tb/tb_ball_frame_latch.sv
// Self-checking bench for ball_frame_latch: frame-level model plus directed literal checks.
module tb_ball_frame_latch;

  // Narrow frame counter keeps the wrap test short.
  localparam int FW = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               screenEnd = 1'b1;
  logic signed [31:0] ball_x = 32'sd100;
  logic signed [31:0] ball_y = 32'sd50;
  logic        [9:0]  hcount = '0;
  logic        [8:0]  vcount = '0;
  logic               pix_valid = 1'b0;
  logic        [9:0]  ball_px;
  logic        [8:0]  ball_py;
  logic               pos_valid;
  logic               frame_tick;
  logic [FW-1:0]      frame_count;
  logic               oob;
  logic               ball_pix;
  logic               pix_valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  ball_frame_latch #(.FCNT_W(FW)) dut (
    .clock         (clock),
    .reset         (reset),
    .screenEnd     (screenEnd),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .hcount        (hcount),
    .vcount        (vcount),
    .pix_valid     (pix_valid),
    .ball_px       (ball_px),
    .ball_py       (ball_py),
    .pos_valid     (pos_valid),
    .frame_tick    (frame_tick),
    .frame_count   (frame_count),
    .oob           (oob),
    .ball_pix      (ball_pix),
    .pix_valid_out (pix_valid_out)
  );

  always #5 clock = ~clock;

  // ---------------- model ----------------
  int m_px = 0, m_py = 0, m_cnt = 0;
  bit m_oob = 0, m_valid = 0, m_se = 1, e_tick = 0;
  bit s1_hit = 0, s1_v = 0, e_pix = 0, e_pv = 0;

  function automatic int clampv(longint v, int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return int'(v);
  endfunction

  function automatic bit in_box(int h, int v, int px, int py);
    return (h >= px) && (h < px + 8) && (v >= py) && (v < py + 8);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_px <= 0; m_py <= 0; m_cnt <= 0; m_oob <= 0; m_valid <= 0; m_se <= 1;
      e_tick <= 0; s1_hit <= 0; s1_v <= 0; e_pix <= 0; e_pv <= 0;
    end else begin
      e_pix  <= s1_hit && s1_v && m_valid;
      e_pv   <= s1_v;
      s1_hit <= in_box(int'(hcount), int'(vcount), m_px, m_py);
      s1_v   <= pix_valid;
      e_tick <= 0;
      if (screenEnd && !m_se) begin
        m_px    <= clampv(longint'(ball_x), 632);
        m_py    <= clampv(longint'(ball_y), 472);
        m_oob   <= (ball_x < 0) || (ball_x > 632) || (ball_y < 0) || (ball_y > 472);
        m_cnt   <= (m_cnt + 1) % (1 << FW);
        m_valid <= 1;
        e_tick  <= 1;
      end
      m_se <= screenEnd;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("m_ball_px", 32'(ball_px), 32'(m_px));
    chk("m_ball_py", 32'(ball_py), 32'(m_py));
    chk("m_pos_valid", 32'(pos_valid), 32'(m_valid));
    chk("m_frame_tick", 32'(frame_tick), 32'(e_tick));
    chk("m_frame_count", 32'(frame_count), 32'(m_cnt));
    chk("m_oob", 32'(oob), 32'(m_oob));
    chk("m_ball_pix", 32'(ball_pix), 32'(e_pix));
    chk("m_pix_valid_out", 32'(pix_valid_out), 32'(e_pv));
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rise();
    screenEnd = 1'b0;
    step(1);
    screenEnd = 1'b1;
    step(1);
  endtask

  initial begin
    step(2);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_pos_valid", 32'(pos_valid), 0);
    reset = 1'b1;
    step(3);
    chk("held_blank_tick", 32'(frame_tick), 0);
    chk("held_blank_pos_valid", 32'(pos_valid), 0);
    rise();
    chk("first_tick", 32'(frame_tick), 1);
    chk("first_px", 32'(ball_px), 100);
    chk("first_count", 32'(frame_count), 1);
    chk("first_pos_valid", 32'(pos_valid), 1);
    step(1);
    chk("tick_one_cycle", 32'(frame_tick), 0);

    ball_x = -32'sd5; ball_y = 32'sd500;
    rise();
    chk("clamp_lo_px", 32'(ball_px), 0);
    chk("clamp_hi_py", 32'(ball_py), 472);
    chk("clamp_oob", 32'(oob), 1);
    ball_x = 32'sd632; ball_y = 32'sd0;
    rise();
    chk("edge_px", 32'(ball_px), 632);
    chk("edge_py", 32'(ball_py), 0);
    chk("edge_oob", 32'(oob), 0);

    ball_x = 32'sd100; ball_y = 32'sd50;
    rise();
    pix_valid = 1'b1; vcount = 9'd50;
    for (int h = 98; h <= 109; h++) begin
      hcount = 10'(h);
      step(1);
    end
    hcount = 10'd108; step(2);
    chk("hit_108", 32'(ball_pix), 0);
    hcount = 10'd100; step(1);
    chk("hit_latency_1", 32'(ball_pix), 0);
    step(1);
    chk("hit_latency_2", 32'(ball_pix), 1);
    chk("pvo_aligned", 32'(pix_valid_out), 1);
    hcount = 10'd107; step(2);
    chk("hit_107", 32'(ball_pix), 1);
    hcount = 10'd99; step(2);
    chk("hit_99", 32'(ball_pix), 0);
    hcount = 10'd100; vcount = 9'd58; step(2);
    chk("hit_v58", 32'(ball_pix), 0);
    vcount = 9'd57; step(2);
    chk("hit_v57", 32'(ball_pix), 1);
    pix_valid = 1'b0; step(2);
    chk("novalid_pix", 32'(ball_pix), 0);
    chk("novalid_pvo", 32'(pix_valid_out), 0);

    ball_x = 32'sd632;
    rise();
    pix_valid = 1'b1; hcount = 10'd639; vcount = 9'd50; step(2);
    chk("hit_639_nowrap", 32'(ball_pix), 1);
    hcount = 10'd640; step(2);
    chk("hit_640", 32'(ball_pix), 0);

    ball_x = 32'sd100;
    rise();
    ball_x = 32'sd200; hcount = 10'd100; step(3);
    chk("midframe_px_held", 32'(ball_px), 100);
    chk("midframe_hit_held", 32'(ball_pix), 1);
    screenEnd = 1'b0; step(1);
    screenEnd = 1'b1; step(1);
    chk("new_px", 32'(ball_px), 200);
    step(1);
    chk("rise_cycle_old_pos", 32'(ball_pix), 1);
    step(1);
    chk("after_rise_new_pos", 32'(ball_pix), 0);

    for (int i = 0; i < 600 && m_cnt != (1 << FW) - 1; i++) rise();
    chk("pre_wrap_count", 32'(frame_count), 32'((1 << FW) - 1));
    rise();
    chk("wrap_count", 32'(frame_count), 0);
    chk("wrap_tick", 32'(frame_tick), 1);

    ball_x = 32'sd100;
    rise();
    hcount = 10'd100; vcount = 9'd50; pix_valid = 1'b1; step(2);
    chk("pre_reset_hit", 32'(ball_pix), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pix", 32'(ball_pix), 0);
    chk("async_rst_pvo", 32'(pix_valid_out), 0);
    chk("async_rst_pos_valid", 32'(pos_valid), 0);
    chk("async_rst_count", 32'(frame_count), 0);
    @(posedge clock);
    #1 reset = 1'b1;
    step(4);
    chk("post_rst_pix", 32'(ball_pix), 0);
    chk("post_rst_pos_valid", 32'(pos_valid), 0);
    rise();
    chk("post_rst_rise_valid", 32'(pos_valid), 1);
    step(2);
    chk("post_rst_hit", 32'(ball_pix), 1);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
